// File: rtl/ah_merge_pkg.sv
// Shared constants and types for the round-robin merge stage.
package ah_merge_pkg;

  localparam int DATA_W    = 85;
  localparam int NUM_ING   = 15;
  localparam int SRC_W     = $clog2(NUM_ING);

  // Depth of the registered egress buffer; two entries give full
  // throughput while keeping ingress ready a function of registered state.
  localparam int BUF_DEPTH = 2;

  // Buffer occupancy counter (0..BUF_DEPTH)
  typedef logic [1:0] cnt_t;

  // One buffered beat: originating channel plus payload
  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/ah_rr_arbiter.sv
// Rotating-priority arbiter: searches req upward from (last_grant+1) mod
// NUM_ING and remembers the winner only when the caller says the grant
// was actually consumed (advance), so a stalled grant keeps its slot.
module ah_rr_arbiter #(
  parameter int NUM_ING = 15,
  parameter int SRC_W   = $clog2(NUM_ING)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_ING-1:0] req,
  input  logic               advance,
  output logic [NUM_ING-1:0] gnt_onehot,
  output logic [SRC_W-1:0]   gnt_idx
);
  import ah_merge_pkg::*;

  // Reset pointer sits on the last channel so channel 0 wins first.
  localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NUM_ING - 1);
  // One extra bit so last+k (max 2*NUM_ING-1) never overflows before wrap.
  localparam logic [SRC_W:0]   N_W      = (SRC_W + 1)'(NUM_ING);

  logic [SRC_W-1:0] last_q, last_d;
  logic [SRC_W:0]   cand;
  logic             found;

  // Priority search: first requesting index after the last grant, wrapping
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_ING; k++) begin
      cand = {1'b0, last_q} + (SRC_W + 1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (!found && req[cand[SRC_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[SRC_W-1:0];
      end
    end
  end

  // One-hot view of the grant; all zero when nothing requests
  always_comb begin
    gnt_onehot = '0;
    for (int i = 0; i < NUM_ING; i++) begin
      gnt_onehot[i] = found && (gnt_idx == SRC_W'(i));
    end
  end

  // Pointer moves only on a consumed grant
  always_comb begin
    last_d = last_q;
    if (advance) last_d = gnt_idx;
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= LAST_RST;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/ah_rr_merge.sv
// Merge stage: round-robin arbitration across NUM_ING valid/ready ingress
// channels into a 2-entry registered egress buffer that also carries the
// source index. Ingress ready depends only on buffer occupancy, so the
// downstream egr_ready never reaches the upstream ready chain.
module ah_rr_merge #(
  parameter int DATA_W  = ah_merge_pkg::DATA_W,
  parameter int NUM_ING = ah_merge_pkg::NUM_ING,
  parameter int SRC_W   = $clog2(NUM_ING)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_ING*DATA_W-1:0] ing_data,
  input  logic [NUM_ING-1:0]        ing_valid,
  output logic [NUM_ING-1:0]        ing_ready,
  output logic [DATA_W-1:0]         egr_data,
  output logic [SRC_W-1:0]          egr_src,
  output logic                      egr_valid,
  input  logic                      egr_ready
);
  import ah_merge_pkg::*;

  // Local beat type follows this instance's parameters
  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } mbeat_t;

  localparam cnt_t DEPTH = cnt_t'(BUF_DEPTH);

  logic [NUM_ING-1:0] gnt_oh;
  logic [SRC_W-1:0]   gnt_idx;
  logic               accept, push, pop;
  mbeat_t             in_beat;
  mbeat_t             head_q, head_d, tail_q, tail_d;
  cnt_t               cnt_q, cnt_d;

  // Registered-state-only accept; held low during reset so no channel
  // sees ready while rst_n is asserted.
  assign accept    = rst_n && (cnt_q < DEPTH);
  assign ing_ready = gnt_oh & {NUM_ING{accept}};
  assign push      = |(ing_valid & ing_ready);
  assign pop       = egr_valid & egr_ready;

  ah_rr_arbiter #(
    .NUM_ING (NUM_ING),
    .SRC_W   (SRC_W)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (ing_valid),
    .advance    (push),
    .gnt_onehot (gnt_oh),
    .gnt_idx    (gnt_idx)
  );

  // Payload mux driven by the one-hot grant
  always_comb begin
    in_beat.src  = gnt_idx;
    in_beat.data = '0;
    for (int i = 0; i < NUM_ING; i++) begin
      if (gnt_oh[i]) in_beat.data = ing_data[i*DATA_W +: DATA_W];
    end
  end

  // Two-slot buffer: head always drives egress, tail shifts in on pop.
  // Push+pop can only happen at count 1 (count 2 blocks accept, count 0
  // has no valid head), so the new beat lands straight in the head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == '0) head_d = in_beat;
        else             tail_d = in_beat;
        cnt_d = cnt_q + cnt_t'(1);
      end
      2'b01: begin
        if (cnt_q == DEPTH) head_d = tail_q;
        cnt_d = cnt_q - cnt_t'(1);
      end
      2'b11: head_d = in_beat;
      default: ;
    endcase
  end

  // Buffer state registers; reset discards any buffered beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign egr_valid = (cnt_q != '0);
  assign egr_data  = head_q.data;
  assign egr_src   = head_q.src;

endmodule

// File: tb/tb_ah_rr_merge.sv
// Bench for ah_rr_merge: directed scenarios plus a long random run, all
// checked against a queue-based model of arbitration and buffering.
module tb_ah_rr_merge;
  localparam int DW = 85;
  localparam int N  = 15;
  localparam int SW = 4;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
  } tbeat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*DW-1:0]   ing_data;
  logic [N-1:0]      ing_valid;
  logic [N-1:0]      ing_ready;
  logic [DW-1:0]     egr_data;
  logic [SW-1:0]     egr_src;
  logic              egr_valid;
  logic              egr_ready;

  logic [DW-1:0]     chdata [N];
  tbeat_t            mq [$];
  int                m_last;
  int                n_chk = 0;
  int                n_bad = 0;

  ah_rr_merge #(.DATA_W(DW), .NUM_ING(N), .SRC_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ing_data  (ing_data),
    .ing_valid (ing_valid),
    .ing_ready (ing_ready),
    .egr_data  (egr_data),
    .egr_src   (egr_src),
    .egr_valid (egr_valid),
    .egr_ready (egr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Spec-level arbitration: first valid index scanning up from last+1
  function automatic int model_grant(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One cycle: drive at negedge, check just after, update model at posedge
  task automatic step(input logic [N-1:0] v, input logic er);
    logic [N-1:0] exp_rdy;
    int           g;
    bit           push, pop;
    @(negedge clk);
    ing_valid = v;
    egr_ready = er;
    for (int i = 0; i < N; i++) ing_data[i*DW +: DW] = chdata[i];
    #1;
    g       = model_grant(v, m_last);
    push    = (g >= 0) && (mq.size() < 2);
    exp_rdy = '0;
    if (push) exp_rdy[g] = 1'b1;
    chk("ing_ready", 128'(ing_ready), 128'(exp_rdy));
    chk("ready_onehot", 128'($countones(ing_ready) <= 1), 128'(1));
    chk("egr_valid", 128'(egr_valid), 128'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("egr_src", 128'(egr_src), 128'(mq[0].src));
      chk("egr_data", 128'(egr_data), 128'(mq[0].data));
    end
    pop = (mq.size() != 0) && er;
    @(posedge clk);
    if (pop) mq.delete(0);
    if (push) begin
      mq.push_back('{src: g, data: chdata[g]});
      m_last = g;
    end
  endtask

  // Reset pulse: outputs must drop immediately, before any clock edge
  task automatic do_reset(input logic [N-1:0] v_rel);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_egr_valid", 128'(egr_valid), 128'(0));
    chk("rst_egr_data", 128'(egr_data), 128'(0));
    chk("rst_egr_src", 128'(egr_src), 128'(0));
    chk("rst_ing_ready", 128'(ing_ready), 128'(0));
    mq.delete();
    m_last = N - 1;
    @(posedge clk);
    #2;
    ing_valid = v_rel;
    rst_n = 1'b1;
  endtask

  logic [95:0]  rnd;
  logic [N-1:0] rv;

  initial begin
    rst_n     = 1'b0;
    ing_valid = '0;
    egr_ready = 1'b0;
    ing_data  = '0;
    m_last    = N - 1;
    for (int i = 0; i < N; i++) chdata[i] = '0;

    // 1: reset values with channel 3 valid, then first beat through
    chdata[3]  = 85'h1_2345;
    ing_valid  = 15'h0008;
    egr_ready  = 1'b1;
    for (int i = 0; i < N; i++) ing_data[i*DW +: DW] = chdata[i];
    repeat (2) @(negedge clk);
    #1;
    chk("init_egr_valid", 128'(egr_valid), 128'(0));
    chk("init_egr_data", 128'(egr_data), 128'(0));
    chk("init_egr_src", 128'(egr_src), 128'(0));
    chk("init_ing_ready", 128'(ing_ready), 128'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(15'h0008, 1'b1);
    step(15'h0000, 1'b1);

    // 2: all channels valid, fair rotation from channel 0
    do_reset('0);
    for (int i = 0; i < N; i++) chdata[i] = DW'(i);
    for (int c = 0; c < 30; c++) step('1, 1'b1);
    step('0, 1'b1);

    // 3: channels 2 and 9 under back-pressure, then drain
    for (int c = 0; c < 4; c++) step(15'h0204, 1'b0);
    for (int c = 0; c < 4; c++) step(15'h0204, 1'b1);
    step('0, 1'b1);
    step('0, 1'b1);

    // 4: channel 5 with toggling egress ready
    for (int c = 0; c < 8; c++) step(15'h0020, 1'(c % 2 == 0));
    step('0, 1'b1);
    step('0, 1'b1);

    // 5: reset with beats from 4 and 7 buffered; channel 0 wins afterwards
    step(15'h0010, 1'b0);
    step(15'h0080, 1'b0);
    chk("pre_rst_valid", 128'(egr_valid), 128'(1));
    do_reset(15'h0011);
    step(15'h0011, 1'b1);
    step(15'h0011, 1'b1);
    step('0, 1'b1);

    // 6: random valid, data and egress ready
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        rnd       = {$urandom, $urandom, $urandom};
        chdata[i] = rnd[DW-1:0];
        rv[i]     = ($urandom_range(0, 99) < 40);
      end
      step(rv, 1'($urandom_range(0, 99) < 65));
    end
    for (int c = 0; c < 4; c++) step('0, 1'b1);
    chk("drained", 128'(egr_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
